// File: rtl/sprite_draw_scheduler.sv
// Round-robin sequencer sharing one sprite-draw engine among NUM_REQ requesters.
// Latches the winner's origin/ROM id, runs the engine start/ready handshake and
// pulses ack to the owner when its draw completes.
// Optional feature: define DRAW_TIMEOUT_EN to enable a per-phase watchdog that
// aborts a stuck handshake and flags drawErr alongside ack.
module sprite_draw_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] reqX,
  input  logic [9*NUM_REQ-1:0] reqY,
  input  logic [4*NUM_REQ-1:0] reqRomId,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           drawX,
  output logic [8:0]           drawY,
  output logic [3:0]           drawRomId,
  output logic                 drawStart,
  input  logic                 drawReady,
  output logic                 busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic [15:0]          drawCount,
  output logic                 drawErr
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

  state_e          state;
  logic [IdxW-1:0] last_grant;
  logic [IdxW-1:0] cur_idx;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;
  logic            win_found;
  logic            timeout_hit;

`ifdef DRAW_TIMEOUT_EN
  localparam logic [23:0] WdogLast = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] wdog;
  // Watchdog fires on the last allowed cycle of a START or BUSY phase.
  assign timeout_hit = (wdog == WdogLast);
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign drawErr     = 1'b0;
`endif

  // Search requests starting just after the last owner, wrapping; first set bit wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_grant) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Handshake FSM; every output is a register updated here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      last_grant <= IdxW'(NUM_REQ - 1);
      cur_idx    <= '0;
      ack        <= '0;
      grant      <= '0;
      drawX      <= '0;
      drawY      <= '0;
      drawRomId  <= '0;
      drawStart  <= 1'b0;
      busy       <= 1'b0;
      drawCount  <= '0;
`ifdef DRAW_TIMEOUT_EN
      wdog       <= '0;
      drawErr    <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef DRAW_TIMEOUT_EN
      drawErr <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (drawReady && win_found) begin
            drawX     <= reqX[8*32'(win_idx) +: 8];
            drawY     <= reqY[9*32'(win_idx) +: 9];
            drawRomId <= reqRomId[4*32'(win_idx) +: 4];
            grant     <= NUM_REQ'(1) << win_idx;
            cur_idx   <= win_idx;
            busy      <= 1'b1;
            state     <= StStart;
`ifdef DRAW_TIMEOUT_EN
            wdog      <= '0;
`endif
          end
        end
        StStart: begin
          if (!drawReady) begin
            drawStart <= 1'b0;
            state     <= StBusy;
`ifdef DRAW_TIMEOUT_EN
            wdog      <= '0;
`endif
          end else if (timeout_hit) begin
            drawStart <= 1'b0;
            ack       <= grant;
            state     <= StDone;
`ifdef DRAW_TIMEOUT_EN
            drawErr   <= 1'b1;
`endif
          end else begin
            drawStart <= 1'b1;
`ifdef DRAW_TIMEOUT_EN
            wdog      <= wdog + 24'd1;
`endif
          end
        end
        StBusy: begin
          drawStart <= 1'b0;
          if (drawReady) begin
            ack       <= grant;
            drawCount <= drawCount + 16'd1;
            state     <= StDone;
          end else if (timeout_hit) begin
            ack       <= grant;
            state     <= StDone;
`ifdef DRAW_TIMEOUT_EN
            drawErr   <= 1'b1;
`endif
          end else begin
`ifdef DRAW_TIMEOUT_EN
            wdog      <= wdog + 24'd1;
`endif
          end
        end
        StDone: begin
          grant      <= '0;
          busy       <= 1'b0;
          last_grant <= cur_idx;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler with a small behavioural draw engine.
// Define DRAW_TIMEOUT_EN to also exercise the watchdog abort (TIMEOUT_CYCLES=100).
module tb_sprite_draw_scheduler;

  localparam int NR = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [8*NR-1:0] reqX = '0;
  logic [9*NR-1:0] reqY = '0;
  logic [4*NR-1:0] reqRomId = '0;
  logic [NR-1:0]   ack;
  logic [7:0]      drawX;
  logic [8:0]      drawY;
  logic [3:0]      drawRomId;
  logic            drawStart;
  logic            drawReady;
  logic            busy;
  logic [NR-1:0]   grant;
  logic [15:0]     drawCount;
  logic            drawErr;

  int checks = 0;
  int errors = 0;

  // Engine model knobs
  int eng_delay = 3;
  int eng_len = 50;
  bit eng_never = 1'b0;
  bit eng_hold_low = 1'b0;
  logic eng_ready;
  int eng_st;
  int eng_cnt;

  sprite_draw_scheduler #(
    .NUM_REQ(NR),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .reqX(reqX),
    .reqY(reqY),
    .reqRomId(reqRomId),
    .ack(ack),
    .drawX(drawX),
    .drawY(drawY),
    .drawRomId(drawRomId),
    .drawStart(drawStart),
    .drawReady(drawReady),
    .busy(busy),
    .grant(grant),
    .drawCount(drawCount),
    .drawErr(drawErr)
  );

  always #5 clock = ~clock;

  assign drawReady = eng_ready & ~eng_hold_low;

  // Engine: accept start, drop ready after eng_delay cycles, raise it after eng_len more.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_ready <= 1'b1;
      eng_st    <= 0;
      eng_cnt   <= 0;
    end else begin
      case (eng_st)
        0: if (drawStart && drawReady && !eng_never) begin
          eng_st  <= 1;
          eng_cnt <= 1;
        end
        1: if (eng_cnt >= eng_delay) begin
          eng_ready <= 1'b0;
          eng_st    <= 2;
          eng_cnt   <= 1;
        end else eng_cnt <= eng_cnt + 1;
        default: if (eng_cnt >= eng_len) begin
          eng_ready <= 1'b1;
          eng_st    <= 0;
        end else eng_cnt <= eng_cnt + 1;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic set_data(input int i, input logic [7:0] x, input logic [8:0] y,
                          input logic [3:0] r);
    reqX[8*i +: 8]     = x;
    reqY[9*i +: 9]     = y;
    reqRomId[4*i +: 4] = r;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Wait for an ack; the acked requester drops its request immediately.
  task automatic wait_ack(input int budget, output logic [NR-1:0] seen, output bit to);
    seen = '0;
    to   = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (ack != '0) begin
        seen = ack;
        req  = req & ~ack;
        to   = 1'b0;
        break;
      end
    end
  endtask

  // Wait until the scheduler sits in BUSY (busy, start released, engine drawing).
  task automatic wait_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (busy && !drawStart && !drawReady) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL rst_ack got %h want 0", ack); end
    checks++; if (grant !== 4'h0) begin errors++; $display("FAIL rst_grant got %h want 0", grant); end
    checks++; if ({drawX, drawY, drawRomId} !== 21'h0) begin
      errors++; $display("FAIL rst_draw got %h/%h/%h want 0", drawX, drawY, drawRomId);
    end
    checks++; if ({drawStart, busy, drawErr} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b want 000", {drawStart, busy, drawErr});
    end
    checks++; if (drawCount !== 16'h0) begin errors++; $display("FAIL rst_count got %h want 0", drawCount); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [NR-1:0] seen;
    bit to;
    bit fell;
    eng_delay = 3;
    eng_len   = 50;
    req = 4'b0100;
    @(negedge clock);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL t1_grant got %b want 0100", grant); end
    checks++; if ({drawX, drawY, drawRomId} !== {8'd10, 9'd20, 4'd3}) begin
      errors++; $display("FAIL t1_latch got %0d/%0d/%0d want 10/20/3", drawX, drawY, drawRomId);
    end
    checks++; if ({busy, drawStart} !== 2'b10) begin
      errors++; $display("FAIL t1_start0 got busy=%b start=%b want 1/0", busy, drawStart);
    end
    @(negedge clock);
    checks++; if (drawStart !== 1'b1) begin errors++; $display("FAIL t1_start1 got %b want 1", drawStart); end
    fell = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!drawStart) begin
        fell = 1'b1;
        break;
      end
    end
    checks++; if ({fell, drawReady} !== 2'b10) begin
      errors++; $display("FAIL t1_start_fall got fell=%b ready=%b want 1/0", fell, drawReady);
    end
    wait_ack(200, seen, to);
    checks++; if (to) begin errors++; $display("FAIL t1_ack_timeout got none want ack"); end
    checks++; if (seen !== 4'b0100) begin errors++; $display("FAIL t1_ack got %b want 0100", seen); end
    checks++; if (drawCount !== 16'd1) begin errors++; $display("FAIL t1_count got %0d want 1", drawCount); end
    checks++; if (drawErr !== 1'b0) begin errors++; $display("FAIL t1_err got %b want 0", drawErr); end
    @(negedge clock);
    checks++; if ({ack, grant, busy} !== 9'h0) begin
      errors++; $display("FAIL t1_after got ack=%b grant=%b busy=%b want 0", ack, grant, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] seen;
    logic [NR-1:0] exp_order [5];
    bit to;
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b1000;
    exp_order[3] = 4'b0001;
    exp_order[4] = 4'b1000;
    eng_len = 5;
    do_reset();
    req = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        @(negedge clock);
        req = 4'b1001;
      end
      wait_ack(100, seen, to);
      checks++; if (seen !== exp_order[k]) begin
        errors++; $display("FAIL t2_order%0d got %b want %b", k, seen, exp_order[k]);
      end
    end
    checks++; if (drawCount !== 16'd5) begin errors++; $display("FAIL t2_count got %0d want 5", drawCount); end
  endtask

  task automatic test_ready_low();
    logic [NR-1:0] seen;
    bit to;
    int bad;
    reset = 1'b1;
    eng_hold_low = 1'b1;
    req = 4'b0001;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (drawStart !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t3_hold got %0d active cycles want 0", bad); end
    eng_hold_low = 1'b0;
    wait_ack(100, seen, to);
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL t3_ack got %b want 0001", seen); end
    checks++; if (drawCount !== 16'd1) begin errors++; $display("FAIL t3_count got %0d want 1", drawCount); end
  endtask

  task automatic test_reset_busy();
    logic [NR-1:0] seen;
    bit to;
    bit ok;
    eng_len = 50;
    @(negedge clock);
    req = 4'b0001;
    wait_busy(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_reach_busy got none want busy"); end
    req = 4'b0011;
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({ack, grant, drawStart, busy, drawErr} !== 11'h0) begin
      errors++; $display("FAIL t4_rst_flags got ack=%b grant=%b start=%b busy=%b want 0",
                         ack, grant, drawStart, busy);
    end
    checks++; if ({drawX, drawY, drawRomId, drawCount} !== 37'h0) begin
      errors++; $display("FAIL t4_rst_data got %h/%h/%h/%h want 0", drawX, drawY, drawRomId, drawCount);
    end
    @(negedge clock);
    reset = 1'b0;
    req = 4'b0010;
    wait_ack(200, seen, to);
    checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL t4_ack got %b want 0010", seen); end
    checks++; if (drawCount !== 16'd1) begin errors++; $display("FAIL t4_count got %0d want 1", drawCount); end
  endtask

  task automatic test_no_preempt();
    logic [NR-1:0] seen;
    bit to;
    bit ok;
    int bad;
    eng_len = 30;
    @(negedge clock);
    req = 4'b0001;
    wait_busy(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_reach_busy got none want busy"); end
    // Requester 1 arrives and requester 0 drops mid-draw.
    req = 4'b0010;
    bad  = 0;
    seen = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (grant !== 4'b0001 || drawX !== 8'h11 || drawY !== 9'h101) bad++;
      if (ack != '0) begin
        seen = ack;
        break;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t6_stable got %0d changes want 0", bad); end
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL t6_ack0 got %b want 0001", seen); end
    checks++; if (drawCount !== 16'd2) begin errors++; $display("FAIL t6_count got %0d want 2", drawCount); end
    wait_ack(200, seen, to);
    checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL t6_ack1 got %b want 0010", seen); end
    checks++; if ({drawX, drawY, drawRomId} !== {8'h22, 9'h0A2, 4'd2}) begin
      errors++; $display("FAIL t6_latch1 got %h/%h/%h want 22/0a2/2", drawX, drawY, drawRomId);
    end
  endtask

`ifdef DRAW_TIMEOUT_EN
  task automatic test_timeout();
    int start_cyc;
    bit got;
    do_reset();
    eng_never = 1'b1;
    req = 4'b0001;
    start_cyc = 0;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (ack != '0) begin
        got = 1'b1;
        break;
      end
      if (grant != '0) start_cyc++;
    end
    checks++; if (!got) begin errors++; $display("FAIL t5_ack_timeout got none want ack"); end
    checks++; if (start_cyc !== 100) begin
      errors++; $display("FAIL t5_start_cycles got %0d want 100", start_cyc);
    end
    checks++; if ({ack, drawErr, drawStart} !== 6'b0001_1_0) begin
      errors++; $display("FAIL t5_abort got ack=%b err=%b start=%b want 0001/1/0", ack, drawErr, drawStart);
    end
    checks++; if (drawCount !== 16'd0) begin errors++; $display("FAIL t5_count got %0d want 0", drawCount); end
    req = 4'b0000;
    @(negedge clock);
    checks++; if ({drawErr, grant} !== 5'h0) begin
      errors++; $display("FAIL t5_after got err=%b grant=%b want 0", drawErr, grant);
    end
    eng_never = 1'b0;
  endtask
`endif

  initial begin
    set_data(0, 8'h11, 9'h101, 4'd1);
    set_data(1, 8'h22, 9'h0A2, 4'd2);
    set_data(2, 8'd10, 9'd20, 4'd3);
    set_data(3, 8'hF0, 9'h1FF, 4'hF);
    test_reset();
    test_single();
    test_round_robin();
    test_ready_low();
    test_reset_busy();
    test_no_preempt();
`ifdef DRAW_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
